ksa_seq_ctrl: RTL and testbench

KSA_SEQ_CTRL -- requirements
Module: ksa_seq_ctrl

---
 rtl/ksa_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_ksa_seq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ksa_seq_ctrl.sv
// Sequential adder/subtractor: one 4-bit Kogge-Stone slice reused once per nibble.
// Optional KSA_SEQ_OVF_EN adds a registered signed-overflow output (ovf).
module ksa_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KSA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [KW-1:0]    k;

  logic [3:0] a_n, b_n, g, p, g1, p1, g2, c_vec, s4;
  logic       c4;
  logic       last_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign last_c = (k == KW'(N - 1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // 4-bit Kogge-Stone slice; carry-in folded into bit 0 generate
  always_comb begin
    a_n = a_r[{k, 2'b00} +: 4];
    b_n = b_r[{k, 2'b00} +: 4];
    g   = a_n & b_n;
    p   = a_n ^ b_n;
    g1[0] = g[0] | (p[0] & carry);
    p1[0] = p[0];
    g1[1] = g[1] | (p[1] & g1[0]);
    p1[1] = p[1] & p[0];
    g1[2] = g[2] | (p[2] & g[1]);
    p1[2] = p[2] & p[1];
    g1[3] = g[3] | (p[3] & g[2]);
    p1[3] = p[3] & p[2];
    g2[0] = g1[0];
    g2[1] = g1[1];
    g2[2] = g1[2] | (p1[2] & g1[0]);
    g2[3] = g1[3] | (p1[3] & g1[1]);
    c_vec = {g2[2:0], carry};
    c4    = g2[3];
    s4    = p ^ c_vec;
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      carry     <= 1'b0;
      k         <= '0;
`ifdef KSA_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            k     <= '0;
          end
        end
        RUN: begin
          sum[{k, 2'b00} +: 4] <= s4;
          carry <= c4;
          k     <= k + KW'(1);
          if (last_c) begin
            cout <= c4;
`ifdef KSA_SEQ_OVF_EN
            ovf  <= c4 ^ c_vec[3];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// Directed self-checking bench for ksa_seq_ctrl at WIDTH=16.
// Checks ovf as well when compiled with KSA_SEQ_OVF_EN.
module tb_ksa_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;
`ifdef KSA_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  ksa_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef KSA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with latency and result checks
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic [15:0] esum, input logic ecout,
                        input logic eovf);
    int lat;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = ~ta; b = 16'h5A5A; sub = ~ts;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef KSA_SEQ_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`endif
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  logic [16:0] ref_q[$];
  logic        ovf_q[$];
  logic [16:0] r;
  logic [15:0] hs, rs;
  logic        acc, e_ovf;
  int          last_acc, n_acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #12;
    check("rst_state", 32'({in_ready, out_valid, cout}), 32'b100);
    check("rst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("add1",   16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_neg",16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("ovf_add",16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub",16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_eq", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("mixed",  16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);

    // Stall in DONE while disturbing inputs
    a = 16'h1234; b = 16'h0FCD; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 16'(i * 16'h1111); b = ~a;
      tick();
      check("hold_sum", 32'(sum), 32'h2201);
      check("hold_hs", 32'({out_valid, in_ready, cout}), 32'b100);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_rel", 32'({out_valid, in_ready}), 32'b01);

    // Abort in RUN at k=2
    a = 16'hF0F0; b = 16'h0F0F; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("abort_hs", 32'({out_valid, in_ready}), 32'b01);
    check("abort_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Back-to-back traffic against a reference model
    in_valid = 1'b1; out_ready = 1'b1;
    a = 16'h8001; b = 16'h7FFF; sub = 1'b0;
    last_acc = -1; n_acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = in_ready;
      hs = a; rs = sub ? ~b : b;
      tick();
      if (acc) begin
        r = {1'b0, hs} + {1'b0, rs} + 17'(sub);
        e_ovf = (hs[15] == rs[15]) && (r[15] != hs[15]);
        ref_q.push_back(r);
        ovf_q.push_back(e_ovf);
        if (last_acc >= 0) check("b2b_space", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc; n_acc++;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      end
      if (out_valid) begin
        if (ref_q.size() == 0) begin
          check("b2b_extra", 32'd1, 32'd0);
        end else begin
          r = ref_q.pop_front();
          e_ovf = ovf_q.pop_front();
          check("b2b_sum", 32'({cout, sum}), 32'(r));
`ifdef KSA_SEQ_OVF_EN
          check("b2b_ovf", 32'(ovf), 32'(e_ovf));
`endif
        end
      end
    end
    check("b2b_count", 32'(n_acc >= 6), 32'd1);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
